// File: rtl/vecmac_seq_ctrl_pkg.sv
// Shared definitions for the vector multiply-accumulate sequencer and its helpers.
package vecmac_seq_ctrl_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned PROD_W    = 2 * LANE_W;
  localparam int unsigned SUM_W     = PROD_W + 2;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int unsigned DEF_LEN_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFeed  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/vecmac_lane_sum4.sv
// Combinational adder tree: four packed 16-bit lane products to one 18-bit sum.
module vecmac_lane_sum4
  import vecmac_seq_ctrl_pkg::*;
(
  input  logic [LANES*PROD_W-1:0] product,
  output logic [SUM_W-1:0]        lane_sum
);

  logic [PROD_W:0] pair_lo;
  logic [PROD_W:0] pair_hi;

  always_comb begin
    pair_lo  = {1'b0, product[0*PROD_W +: PROD_W]} + {1'b0, product[1*PROD_W +: PROD_W]};
    pair_hi  = {1'b0, product[2*PROD_W +: PROD_W]} + {1'b0, product[3*PROD_W +: PROD_W]};
    lane_sum = {1'b0, pair_lo} + {1'b0, pair_hi};
  end

endmodule

// File: rtl/vecmac_seq_ctrl.sv
// Dot-product sequencer: streams operand beats into the 4-lane multiplier,
// accumulates the reduced products and returns one scalar per command.
module vecmac_seq_ctrl
  import vecmac_seq_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             mul_in_valid,
  output logic [31:0]      mul_in_a,
  output logic [31:0]      mul_in_b,
  input  logic             mul_out_valid,
  input  logic [63:0]      mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issue_q;
  logic [LEN_W-1:0]   ret_q;
  logic [ACC_W-1:0]   acc_q;
  logic               mul_in_valid_q;
  logic [31:0]        mul_in_a_q;
  logic [31:0]        mul_in_b_q;
  logic [SUM_W-1:0]   lane_sum;
  logic               op_fire;
  logic               ret_fire;

  vecmac_lane_sum4 u_lane_sum4 (
    .product  (mul_product),
    .lane_sum (lane_sum)
  );

  // Returns outside FEED/DRAIN are stray and must not touch the accumulator.
  assign op_fire  = op_valid && op_ready;
  assign ret_fire = mul_out_valid && (state_q == StFeed || state_q == StDrain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      len_q          <= '0;
      issue_q        <= '0;
      ret_q          <= '0;
      acc_q          <= '0;
      mul_in_valid_q <= 1'b0;
      mul_in_a_q     <= '0;
      mul_in_b_q     <= '0;
    end else begin
      mul_in_valid_q <= 1'b0;
      if (op_fire) begin
        mul_in_valid_q <= 1'b1;
        mul_in_a_q     <= op_a;
        mul_in_b_q     <= op_b;
        issue_q        <= issue_q + LEN_W'(1);
      end
      if (ret_fire) begin
        acc_q <= acc_q + ACC_W'(lane_sum);
        ret_q <= ret_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            len_q   <= cmd_len;
            issue_q <= '0;
            ret_q   <= '0;
            acc_q   <= '0;
            state_q <= (cmd_len == '0) ? StDone : StFeed;
          end
        end
        StFeed: begin
          if (op_fire && (issue_q + LEN_W'(1) == len_q)) state_q <= StDrain;
        end
        StDrain: begin
          if (ret_q + LEN_W'(ret_fire) == len_q) state_q <= StDone;
        end
        StDone: begin
          if (res_ready) state_q <= StIdle;
        end
      endcase
    end
  end

  // Every output is forced low while reset is asserted, before the first edge lands.
  always_comb begin
    cmd_ready    = rst_n && (state_q == StIdle);
    op_ready     = rst_n && (state_q == StFeed) && (issue_q < len_q);
    res_valid    = rst_n && (state_q == StDone);
    busy         = rst_n && (state_q != StIdle);
    mul_in_valid = rst_n && mul_in_valid_q;
    mul_in_a     = rst_n ? mul_in_a_q : '0;
    mul_in_b     = rst_n ? mul_in_b_q : '0;
    res_data     = rst_n ? acc_q : '0;
  end

endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Self-checking bench: table vectors, reset corner cases and random commands
// against a plain-arithmetic dot-product model, with a behavioural multiplier.
module tb_vecmac_seq_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_len;
  logic        op_valid;
  logic [31:0] op_a, op_b;
  logic        res_ready;
  logic        mul_out_valid;
  logic [63:0] mul_product;

  logic        cmd_ready, op_ready, mul_in_valid, res_valid, busy;
  logic [31:0] mul_in_a, mul_in_b, res_data;
  logic        cmd_ready_w, op_ready_w, mul_in_valid_w, res_valid_w, busy_w;
  logic [31:0] mul_in_a_w, mul_in_b_w;
  logic [19:0] res_data_w;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  typedef struct {
    string  name;
    int     len;
    logic [31:0] a;
    logic [31:0] b;
    int     gap;
    int     hold;
    longint exp32;
    longint exp20;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_in_valid) pulses <= pulses + 1;

  vecmac_seq_ctrl #(.LEN_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_in_valid(mul_in_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_out_valid(mul_out_valid), .mul_product(mul_product), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // Narrow-accumulator copy sees identical traffic; only its wrap point differs.
  vecmac_seq_ctrl #(.LEN_W(16), .ACC_W(20)) dut_w (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_len(cmd_len), .op_valid(op_valid), .op_ready(op_ready_w), .op_a(op_a), .op_b(op_b),
    .mul_in_valid(mul_in_valid_w), .mul_in_a(mul_in_a_w), .mul_in_b(mul_in_b_w),
    .mul_out_valid(mul_out_valid), .mul_product(mul_product), .res_valid(res_valid_w),
    .res_ready(res_ready), .res_data(res_data_w), .busy(busy_w)
  );

  // Behavioural multiplier, latency L, shares the reset.
  logic [63:0]  prod_in;
  logic [L-1:0] mv_q;
  logic [63:0]  mp_q[L];

  always_comb begin
    prod_in = '0;
    for (int j = 0; j < 4; j++)
      prod_in[16*j +: 16] = 16'(mul_in_a[8*j +: 8]) * 16'(mul_in_b[8*j +: 8]);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mv_q <= '0;
      for (int k = 0; k < L; k++) mp_q[k] <= '0;
    end else begin
      mv_q    <= {mv_q[L-2:0], mul_in_valid};
      mp_q[0] <= prod_in;
      for (int k = 1; k < L; k++) mp_q[k] <= mp_q[k-1];
    end
  end

  assign mul_out_valid = mv_q[L-1];
  assign mul_product   = mp_q[L-1];

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(mul_out_valid && (!busy || res_valid))) else begin
        failures <= failures + 1;
        $display("FAIL stray_product: mul_out_valid=1 with busy=%0b res_valid=%0b",
                 busy, res_valid);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_dot(input int len);
    longint s = 0;
    for (int i = 0; i < len; i++)
      for (int j = 0; j < 4; j++)
        s += longint'(qa[i][8*j +: 8]) * longint'(qb[i][8*j +: 8]);
    return s;
  endfunction

  task automatic fill(input int len, input logic [31:0] a, input logic [31:0] b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < len; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cmd_ready"}, cmd_ready, 0);
    check({name, "_op_ready"}, op_ready, 0);
    check({name, "_mul_in_valid"}, mul_in_valid, 0);
    check({name, "_mul_in_a"}, mul_in_a, 0);
    check({name, "_mul_in_b"}, mul_in_b, 0);
    check({name, "_res_valid"}, res_valid, 0);
    check({name, "_res_data"}, res_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_cmd_ready_w"}, cmd_ready_w, 0);
    check({name, "_res_data_w"}, res_data_w, 0);
  endtask

  task automatic issue_cmd(input string name, input int len, output int t_acc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_len   = 16'(len);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) check({name, "_cmd_timeout"}, cmd_ready, 1);
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed_beat(input string name, input logic [31:0] a, input logic [31:0] b,
                           output int t_hs);
    int n = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && n < 100) begin @(negedge clk); n++; end
    if (!op_ready) check({name, "_op_timeout"}, op_ready, 1);
    t_hs = cyc;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input int len, input int gap, input int hold,
                         input longint exp32, input longint exp20);
    int t_acc, t_first, t_hs, t_res, p0, n;
    p0 = pulses;
    t_first = 0;
    issue_cmd(name, len, t_acc);
    for (int i = 0; i < len; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      feed_beat(name, qa[i], qb[i], t_hs);
      if (i == 0) t_first = t_hs;
    end
    if (len > 0) check({name, "_op_ready_low"}, op_ready, 0);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    check({name, "_res_valid"}, res_valid, 1);
    t_res = cyc;
    if (len == 0) check({name, "_latency0"}, t_res, t_acc + 1);
    else if (gap == 0) check({name, "_latency"}, t_res, t_first + len + L + 1);
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_valid"}, res_valid, 1);
      check({name, "_hold_data"}, res_data, exp32);
      check({name, "_hold_cmd_ready"}, cmd_ready, 0);
      @(negedge clk);
    end
    check({name, "_res_data"}, res_data, exp32);
    check({name, "_res_data_w"}, res_data_w, exp20);
    check({name, "_res_valid_w"}, res_valid_w, 1);
    check({name, "_hs_cmd_ready"}, cmd_ready, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, "_post_res_valid"}, res_valid, 0);
    check({name, "_post_cmd_ready"}, cmd_ready, 1);
    check({name, "_pulses"}, pulses - p0, len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc, t_hs;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;

    tbl[0] = '{"single", 1, 32'h01020304, 32'h05060708, 0, 0, 70, 70};
    tbl[1] = '{"all_ones", 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1040400, 1040400};
    tbl[2] = '{"stall", 3, 32'h10203040, 32'h01020304, 2, 5, 1440, 1440};
    tbl[3] = '{"queued", 1, 32'h01010101, 32'h02020202, 0, 0, 8, 8};
    tbl[4] = '{"zero_len", 0, 32'h0, 32'h0, 0, 0, 0, 0};
    tbl[5] = '{"wrap", 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1300500, 251924};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("reset_release_cmd_ready", cmd_ready, 1);
    check("reset_release_busy", busy, 0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].len, tbl[i].a, tbl[i].b);
      run_cmd(tbl[i].name, tbl[i].len, tbl[i].gap, tbl[i].hold, tbl[i].exp32, tbl[i].exp20);
    end

    // Reset after the second beat of a four-beat command.
    issue_cmd("midrst", 4, t_acc);
    feed_beat("midrst", 32'hFFFFFFFF, 32'hFFFFFFFF, t_hs);
    feed_beat("midrst", 32'hFFFFFFFF, 32'hFFFFFFFF, t_hs);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    #1;
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_mul_in_valid", mul_in_valid, 0);
    @(negedge clk);
    fill(1, 32'h01010101, 32'h02020202);
    run_cmd("after_rst", 1, 0, 0, 8, 8);

    for (int r = 0; r < 10; r++) begin
      int len, gap, hold;
      longint s;
      len  = int'($urandom_range(0, 6));
      gap  = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 3));
      qa.delete();
      qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back($urandom);
        qb.push_back($urandom);
      end
      s = model_dot(len);
      run_cmd($sformatf("rand%0d", r), len, gap, hold, s % (64'd1 << 32), s % (64'd1 << 20));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
